abc_sweep_ctrl: RTL and testbench

- Sequencer for the 3-input / 2-output combinational lab datapath (inputs a, b, c; outputs x, y).
- On a start request it drives all 8 input vectors in order, {a,b,c} = 000 to 111, and holds each for a programmable number of clocks.
- It samples x and y at the end of each hold and compares them against expected truth-table masks.
- It reports the captured tables, a mismatch count, the first failing vector and a pass/done status, so the datapath can be exercised in hardware without a bench.

---
 rtl/abc_sweep_ctrl.sv | 167 ++++++++++++++++
 tb/tb_abc_sweep_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/abc_sweep_ctrl.sv
// Sweeps {a,b,c} through all 8 vectors of the lab datapath, holding each for
// HOLD_CYCLES clocks, and checks the sampled x/y against expected truth tables.
module abc_sweep_ctrl #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter logic [7:0]  EXP_X       = 8'hE8,
  parameter logic [7:0]  EXP_Y       = 8'h96
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       x_in,
  input  logic       y_in,
  output logic       a_out,
  output logic       b_out,
  output logic       c_out,
  output logic [2:0] vec_idx,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_cnt,
  output logic [2:0] first_err,
  output logic       first_err_vld,
  output logic [7:0] x_cap,
  output logic [7:0] y_cap
);

  localparam int unsigned HOLD_W = 4;
  localparam int unsigned VEC_W  = 3;
  localparam int unsigned CNT_W  = 4;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [VEC_W-1:0]  VEC_LAST  = VEC_W'(7);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [VEC_W-1:0]  vec_idx_q, vec_idx_d;
  logic [2:0]        abc_q, abc_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic [VEC_W-1:0]  first_err_q, first_err_d;
  logic              first_err_vld_q, first_err_vld_d;
  logic [7:0]        x_cap_q, x_cap_d;
  logic [7:0]        y_cap_q, y_cap_d;
  logic              mismatch_c;

  assign mismatch_c = (x_in != EXP_X[vec_idx_q]) || (y_in != EXP_Y[vec_idx_q]);

  // State and result registers; everything clears immediately on rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      hold_cnt_q      <= '0;
      vec_idx_q       <= '0;
      abc_q           <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      pass_q          <= 1'b0;
      err_cnt_q       <= '0;
      first_err_q     <= '0;
      first_err_vld_q <= 1'b0;
      x_cap_q         <= '0;
      y_cap_q         <= '0;
    end else begin
      state_q         <= state_d;
      hold_cnt_q      <= hold_cnt_d;
      vec_idx_q       <= vec_idx_d;
      abc_q           <= abc_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      pass_q          <= pass_d;
      err_cnt_q       <= err_cnt_d;
      first_err_q     <= first_err_d;
      first_err_vld_q <= first_err_vld_d;
      x_cap_q         <= x_cap_d;
      y_cap_q         <= y_cap_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d         = state_q;
    hold_cnt_d      = hold_cnt_q;
    vec_idx_d       = vec_idx_q;
    pass_d          = pass_q;
    err_cnt_d       = err_cnt_q;
    first_err_d     = first_err_q;
    first_err_vld_d = first_err_vld_q;
    x_cap_d         = x_cap_q;
    y_cap_d         = y_cap_q;

    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d         = DRIVE;
          vec_idx_d       = '0;
          hold_cnt_d      = '0;
          err_cnt_d       = '0;
          x_cap_d         = '0;
          y_cap_d         = '0;
          pass_d          = 1'b0;
          first_err_vld_d = 1'b0;
        end
      end
      DRIVE: begin
        if (abort) begin
          // Abort beats a same-edge sample; partial captures are kept.
          state_d    = IDLE;
          hold_cnt_d = '0;
          pass_d     = 1'b0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          x_cap_d[vec_idx_q] = x_in;
          y_cap_d[vec_idx_q] = y_in;
          hold_cnt_d         = '0;
          if (mismatch_c) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
            if (!first_err_vld_q) begin
              first_err_d     = vec_idx_q;
              first_err_vld_d = 1'b1;
            end
          end
          if (vec_idx_q == VEC_LAST) begin
            state_d = DONE;
            pass_d  = (err_cnt_d == '0);
          end else begin
            vec_idx_d = vec_idx_q + VEC_W'(1);
          end
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      DONE: begin
        state_d    = IDLE;
        hold_cnt_d = '0;
      end
      default: begin
        state_d    = IDLE;
        hold_cnt_d = '0;
      end
    endcase

    busy_d = (state_d == DRIVE);
    done_d = (state_d == DONE);
    abc_d  = (state_d == DRIVE) ? vec_idx_d : 3'b000;
  end

  assign a_out         = abc_q[2];
  assign b_out         = abc_q[1];
  assign c_out         = abc_q[0];
  assign vec_idx       = vec_idx_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_cnt       = err_cnt_q;
  assign first_err     = first_err_q;
  assign first_err_vld = first_err_vld_q;
  assign x_cap         = x_cap_q;
  assign y_cap         = y_cap_q;

endmodule

// File: tb/tb_abc_sweep_ctrl.sv
// Directed bench for abc_sweep_ctrl: a majority/parity datapath model feeds the
// sequencer and a scoreboard of expected run results is checked at each done.
module tb_abc_sweep_ctrl;

  localparam logic [7:0] EXP_X = 8'hE8;
  localparam logic [7:0] EXP_Y = 8'h96;

  logic       clk = 1'b0;
  logic       rst, start, abort, x_in, y_in;
  logic       a_out, b_out, c_out, busy, done, pass, first_err_vld;
  logic [2:0] vec_idx, first_err;
  logic [3:0] err_cnt;
  logic [7:0] x_cap, y_cap;

  int tests  = 0;
  int failed = 0;
  int mode   = 0;

  typedef struct {
    logic [7:0] xc;
    logic [7:0] yc;
    logic [3:0] ec;
    logic [2:0] fe;
    logic       fev;
    logic       ps;
  } res_t;
  res_t sb[$];

  abc_sweep_ctrl #(.HOLD_CYCLES(4), .EXP_X(8'hE8), .EXP_Y(8'h96)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .x_in(x_in), .y_in(y_in),
    .a_out(a_out), .b_out(b_out), .c_out(c_out), .vec_idx(vec_idx), .busy(busy),
    .done(done), .pass(pass), .err_cnt(err_cnt), .first_err(first_err),
    .first_err_vld(first_err_vld), .x_cap(x_cap), .y_cap(y_cap)
  );

  always #5 clk = ~clk;

  // Datapath under test: x = majority, y = parity (or stuck at 0 in mode 1).
  always_comb begin
    x_in = (a_out & b_out) | (a_out & c_out) | (b_out & c_out);
    y_in = (mode == 1) ? 1'b0 : (a_out ^ b_out ^ c_out);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_expected();
    res_t r;
    logic [2:0] v;
    logic xm, ym;
    r.xc = '0; r.yc = '0; r.ec = '0; r.fe = '0; r.fev = 1'b0;
    for (int i = 0; i < 8; i++) begin
      v  = 3'(i);
      xm = (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
      ym = (mode == 1) ? 1'b0 : ^v;
      r.xc[i] = xm;
      r.yc[i] = ym;
      if (xm != EXP_X[i] || ym != EXP_Y[i]) begin
        if (!r.fev) begin
          r.fe  = v;
          r.fev = 1'b1;
        end
        r.ec = r.ec + 4'd1;
      end
    end
    r.ps = (r.ec == 4'd0);
    sb.push_back(r);
  endtask

  task automatic check_results(input string tag);
    res_t r;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    r = sb.pop_front();
    check({tag, "_x_cap"}, 32'(x_cap), 32'(r.xc));
    check({tag, "_y_cap"}, 32'(y_cap), 32'(r.yc));
    check({tag, "_err_cnt"}, 32'(err_cnt), 32'(r.ec));
    check({tag, "_fev"}, 32'(first_err_vld), 32'(r.fev));
    if (r.fev) check({tag, "_first_err"}, 32'(first_err), 32'(r.fe));
    check({tag, "_pass"}, 32'(pass), 32'(r.ps));
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic start_run();
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts edges after the accepting edge until done is seen; -1 on timeout.
  task automatic wait_done(input int re1, input int re2, input int max_edges, output int edge_n);
    edge_n = -1;
    for (int n = 1; n <= max_edges; n++) begin
      start = (n == re1) || (n == re2);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        edge_n = n;
        return;
      end
    end
  endtask

  initial begin
    int edge_n;
    int seen;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ctl", 32'({a_out, b_out, c_out, vec_idx, busy, done, pass, first_err_vld}), 32'd0);
    check("reset_res", 32'({err_cnt, first_err, x_cap, y_cap}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Good datapath: walk the drive sequence edge by edge.
    mode = 0;
    push_expected();
    start_run();
    for (int k = 0; k < 32; k++) begin
      check($sformatf("drv_abc_%0d", k), 32'({a_out, b_out, c_out}), 32'(k / 4));
      check($sformatf("drv_vec_%0d", k), 32'(vec_idx), 32'(k / 4));
      check($sformatf("drv_busy_done_%0d", k), 32'({busy, done}), 32'b10);
      @(posedge clk);
      @(negedge clk);
    end
    check("t1_done_edge32", 32'({done, busy, a_out, b_out, c_out}), 32'b10000);
    check("t1_x_cap_const", 32'(x_cap), 32'h0000_00E8);
    check("t1_y_cap_const", 32'(y_cap), 32'h0000_0096);
    check_results("t1");
    @(posedge clk);
    @(negedge clk);
    check("t1_done_drop", 32'(done), 32'd0);

    // y stuck at 0.
    mode = 1;
    push_expected();
    start_run();
    check("t3_busy", 32'(busy), 32'd1);
    wait_done(-1, -1, 100, edge_n);
    check("t3_done_edge", 32'(edge_n), 32'd32);
    check("t3_y_cap_const", 32'(y_cap), 32'h0);
    check("t3_err_cnt_const", 32'(err_cnt), 32'd4);
    check_results("t3");
    @(negedge clk);

    // Abort sampled at edge 10: vectors 0 and 1 captured only.
    mode = 0;
    start_run();
    repeat (9) begin
      @(posedge clk);
      @(negedge clk);
    end
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    check("t4_idle", 32'({busy, done, a_out, b_out, c_out}), 32'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("t4_no_done", 32'(seen), 32'd0);
    check("t4_pass", 32'(pass), 32'd0);
    check("t4_x_cap", 32'(x_cap), 32'h00);
    check("t4_y_cap", 32'(y_cap), 32'h02);
    check("t4_err_cnt", 32'(err_cnt), 32'd0);

    // Re-pulsed start during the run is ignored.
    push_expected();
    start_run();
    wait_done(5, 20, 100, edge_n);
    check("t5_done_edge", 32'(edge_n), 32'd32);
    check_results("t5");
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("t5_start_abort_busy", 32'({busy, a_out, b_out, c_out}), 32'd0);
    repeat (3) @(negedge clk);
    check("t5_start_abort_idle", 32'({busy, done}), 32'd0);
    check("t5_results_kept", 32'({pass, x_cap, y_cap}), 32'h1_E896);

    // Asynchronous reset mid-run at edge 15.
    start_run();
    repeat (15) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("t6_pre_rst_busy", 32'({busy, a_out, b_out, c_out}), 32'b1011);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_ctl", 32'({a_out, b_out, c_out, vec_idx, busy, done, pass, first_err_vld}), 32'd0);
    check("t6_rst_res", 32'({err_cnt, first_err, x_cap, y_cap}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    push_expected();
    start_run();
    wait_done(-1, -1, 100, edge_n);
    check("t6_done_edge", 32'(edge_n), 32'd32);
    check_results("t6");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
